// File: rtl/pipe_pkg.sv
// Shared types and constants for the EX/MEM stage: FSM states, M-register
// control bits and the data-bus alignment helper.
package pipe_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } mstate_t;

  localparam int TIMEOUT_DEFAULT = 15;

  typedef struct packed {
    logic wreg;
    logic m2reg;
    logic wmem;
  } ctrl_m_t;

  // Word accesses must have the two low address bits clear.
  function automatic logic misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/pipemem_stage_if.sv
// Request/acknowledge data-memory bus between the MEM stage and the data memory.
interface pipemem_stage_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/pipemem_timer.sv
// Wait-cycle counter for an outstanding bus request; o_tmo flags the last
// allowed wait cycle.
module pipemem_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clock,
  input  logic resetn,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_tmo
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_cnt;

  // Counter: clear has priority over increment.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + CNT_ONE;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_tmo = (r_cnt == CNT_LAST);

endmodule

// File: rtl/pipemem_stage.sv
// EX/MEM pipeline register with a req/ack data-memory access controller,
// upstream stall generation, bus-timeout and misalignment kill.
module pipemem_stage
  import pipe_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            ewreg,
  input  logic            em2reg,
  input  logic            ewmem,
  input  logic [31:0]     ealu,
  input  logic [31:0]     eb,
  input  logic [4:0]      ern,
  pipemem_stage_if.master bus,
  output logic            stall,
  output logic            mwreg,
  output logic            mm2reg,
  output logic [31:0]     mmo,
  output logic [31:0]     malu,
  output logic [4:0]      mrn,
  output logic            mberr,
  output logic            malign
);

  ctrl_m_t     r_ctrl;
  logic [31:0] r_alu;
  logic [31:0] r_b;
  logic [4:0]  r_rn;
  mstate_t     r_state;

  logic w_memop;
  logic w_mis;
  logic w_req;
  logic w_ack;
  logic w_cnt_last;
  logic w_tmo;
  logic w_stall;
  logic w_kill;
  logic w_clr;
  logic w_inc;

  assign w_memop = r_ctrl.m2reg | r_ctrl.wmem;
  assign w_mis   = w_memop & misaligned(r_alu);
  assign w_req   = w_memop & ~w_mis;
  assign w_ack   = w_req & bus.mem_ack;

  // An ack in the last allowed cycle still completes the access.
  assign w_tmo   = (r_state == WAIT) & w_cnt_last & ~w_ack;
  assign w_stall = w_req & ~w_ack & ~w_tmo;
  assign w_kill  = w_mis | w_tmo;

  // Timer control: count only while a request is left unanswered.
  always_comb begin
    w_clr = 1'b1;
    w_inc = 1'b0;
    case (r_state)
      RUN: begin
        if (w_req & ~w_ack) begin
          w_clr = 1'b0;
          w_inc = 1'b1;
        end else begin
          w_clr = 1'b1;
          w_inc = 1'b0;
        end
      end
      WAIT: begin
        if (w_ack | w_tmo) begin
          w_clr = 1'b1;
          w_inc = 1'b0;
        end else begin
          w_clr = 1'b0;
          w_inc = 1'b1;
        end
      end
      default: begin
        w_clr = 1'b1;
        w_inc = 1'b0;
      end
    endcase
  end

  pipemem_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clock  (clock),
    .resetn (resetn),
    .i_clr  (w_clr),
    .i_inc  (w_inc),
    .o_tmo  (w_cnt_last)
  );

  // Access FSM: RUN issues, WAIT holds until ack or timeout.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state <= RUN;
    end else begin
      case (r_state)
        RUN: begin
          if (w_req & ~w_ack) begin
            r_state <= WAIT;
          end else begin
            r_state <= RUN;
          end
        end
        WAIT: begin
          if (w_ack | w_tmo) begin
            r_state <= RUN;
          end else begin
            r_state <= WAIT;
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

  // M register: advances whenever the stage is not stalled.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_ctrl <= '0;
      r_alu  <= 32'h0000_0000;
      r_b    <= 32'h0000_0000;
      r_rn   <= 5'd0;
    end else if (!w_stall) begin
      r_ctrl <= '{wreg: ewreg, m2reg: em2reg, wmem: ewmem};
      r_alu  <= ealu;
      r_b    <= eb;
      r_rn   <= ern;
    end else begin
      r_ctrl <= r_ctrl;
      r_alu  <= r_alu;
      r_b    <= r_b;
      r_rn   <= r_rn;
    end
  end

  assign bus.mem_req   = w_req;
  assign bus.mem_we    = r_ctrl.wmem;
  assign bus.mem_addr  = r_alu;
  assign bus.mem_wdata = r_b;

  assign stall  = w_stall;
  assign mwreg  = r_ctrl.wreg  & ~w_stall & ~w_kill;
  assign mm2reg = r_ctrl.m2reg & ~w_stall & ~w_kill;
  assign mmo    = (r_ctrl.m2reg & w_ack) ? bus.mem_rdata : 32'h0000_0000;
  assign malu   = r_alu;
  assign mrn    = r_rn;
  assign mberr  = w_tmo;
  assign malign = w_mis;

endmodule

// File: tb/tb_pipemem_stage.sv
// Directed, table-driven bench for pipemem_stage with TIMEOUT=4.
module tb_pipemem_stage;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        mwreg;
    logic        mm2reg;
    logic [31:0] mmo;
    logic [31:0] malu;
    logic [4:0]  mrn;
    logic        mberr;
    logic        malign;
  } outs_t;

  typedef struct packed {
    logic [2:0]  ctl;   // {wreg, m2reg, wmem}
    logic [31:0] ealu;
    logic [31:0] eb;
    logic [4:0]  ern;
    logic        ack;
    logic [31:0] rdata;
    outs_t       exp;
  } vec_t;

  localparam logic [2:0] NOP = 3'b000;
  localparam logic [2:0] ALU = 3'b100;
  localparam logic [2:0] LD  = 3'b110;
  localparam logic [2:0] ST  = 3'b001;

  logic        clock = 1'b0;
  logic        resetn;
  logic        ewreg, em2reg, ewmem;
  logic [31:0] ealu, eb;
  logic [4:0]  ern;
  logic        stall, mwreg, mm2reg, mberr, malign;
  logic [31:0] mmo, malu;
  logic [4:0]  mrn;
  outs_t       act;

  int n_tests = 0;
  int n_fail  = 0;

  pipemem_stage_if bus ();

  pipemem_stage #(.TIMEOUT(4)) dut (
    .clock  (clock),
    .resetn (resetn),
    .ewreg  (ewreg),
    .em2reg (em2reg),
    .ewmem  (ewmem),
    .ealu   (ealu),
    .eb     (eb),
    .ern    (ern),
    .bus    (bus),
    .stall  (stall),
    .mwreg  (mwreg),
    .mm2reg (mm2reg),
    .mmo    (mmo),
    .malu   (malu),
    .mrn    (mrn),
    .mberr  (mberr),
    .malign (malign)
  );

  always #5 clock = ~clock;

  always_comb act = outs_t'({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata,
                             stall, mwreg, mm2reg, mmo, malu, mrn, mberr, malign});

  function automatic outs_t o(input logic req, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic st, input logic wr,
                              input logic m2, input logic [31:0] mo, input logic [31:0] al,
                              input logic [4:0] rn, input logic be, input logic al_err);
    return outs_t'({req, we, addr, wdata, st, wr, m2, mo, al, rn, be, al_err});
  endfunction

  function automatic vec_t v(input logic [2:0] ctl, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] rn, input logic ack, input logic [31:0] rd,
                             input outs_t exp);
    return vec_t'({ctl, a, b, rn, ack, rd, exp});
  endfunction

  task automatic drive(input logic [2:0] ctl, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rn, input logic ack, input logic [31:0] rd);
    {ewreg, em2reg, ewmem} = ctl;
    ealu = a;
    eb   = b;
    ern  = rn;
    bus.mem_ack   = ack;
    bus.mem_rdata = rd;
  endtask

  task automatic check(input string name, input outs_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  vec_t  tbl[$];
  outs_t z, ss, lw;

  initial begin
    z  = '0;
    ss = o(1'b1, 1'b1, 32'h200, 32'hA5A5A5A5, 1'b1, 1'b0, 1'b0, 32'h0, 32'h200, 5'd0, 1'b0, 1'b0);
    lw = o(1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h40, 5'd3, 1'b0, 1'b0);

    // Each row: E inputs and bus response this cycle, expected outputs from the M register.
    tbl.push_back(v(ALU, 32'h1234, 32'h0, 5'd5, 1'b0, 32'h0, z));
    tbl.push_back(v(LD, 32'h100, 32'h0, 5'd6, 1'b0, 32'h0,
                    o(1'b0, 1'b0, 32'h1234, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h1234, 5'd5, 1'b0, 1'b0)));
    tbl.push_back(v(NOP, 32'h0, 32'h0, 5'd0, 1'b1, 32'hDEADBEEF,
                    o(1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 32'h100, 5'd6, 1'b0, 1'b0)));
    tbl.push_back(v(ST, 32'h200, 32'hA5A5A5A5, 5'd0, 1'b0, 32'h0, z));
    tbl.push_back(v(ALU, 32'h55, 32'h0, 5'd9, 1'b0, 32'h0, ss));
    tbl.push_back(v(ALU, 32'h55, 32'h0, 5'd9, 1'b0, 32'h0, ss));
    tbl.push_back(v(ALU, 32'h55, 32'h0, 5'd9, 1'b0, 32'h0, ss));
    tbl.push_back(v(ALU, 32'h55, 32'h0, 5'd9, 1'b1, 32'h77777777,
                    o(1'b1, 1'b1, 32'h200, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b0, 32'h0, 32'h200, 5'd0, 1'b0, 1'b0)));
    tbl.push_back(v(LD, 32'h40, 32'h0, 5'd3, 1'b0, 32'h0,
                    o(1'b0, 1'b0, 32'h55, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h55, 5'd9, 1'b0, 1'b0)));
    tbl.push_back(v(NOP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0, lw));
    tbl.push_back(v(NOP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0, lw));
    tbl.push_back(v(NOP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0, lw));
    tbl.push_back(v(NOP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0,
                    o(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h40, 5'd3, 1'b1, 1'b0)));
    tbl.push_back(v(LD, 32'h40, 32'h0, 5'd3, 1'b0, 32'h0, z));
    tbl.push_back(v(NOP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0, lw));
    tbl.push_back(v(NOP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0, lw));
    tbl.push_back(v(NOP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0, lw));
    tbl.push_back(v(NOP, 32'h0, 32'h0, 5'd0, 1'b1, 32'h0BADF00D,
                    o(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0BADF00D, 32'h40, 5'd3, 1'b0, 1'b0)));
    tbl.push_back(v(LD, 32'h102, 32'h0, 5'd4, 1'b0, 32'h0, z));
    tbl.push_back(v(ALU, 32'h7, 32'h0, 5'd2, 1'b0, 32'h0,
                    o(1'b0, 1'b0, 32'h102, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h102, 5'd4, 1'b0, 1'b1)));
    tbl.push_back(v(ST, 32'h203, 32'h11223344, 5'd0, 1'b0, 32'h0,
                    o(1'b0, 1'b0, 32'h7, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h7, 5'd2, 1'b0, 1'b0)));
    tbl.push_back(v(NOP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0,
                    o(1'b0, 1'b1, 32'h203, 32'h11223344, 1'b0, 1'b0, 1'b0, 32'h0, 32'h203, 5'd0, 1'b0, 1'b1)));
    tbl.push_back(v(ST, 32'h300, 32'hCAFEF00D, 5'd8, 1'b0, 32'h0, z));
    tbl.push_back(v(NOP, 32'h0, 32'h0, 5'd0, 1'b1, 32'hFFFFFFFF,
                    o(1'b1, 1'b1, 32'h300, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0, 32'h0, 32'h300, 5'd8, 1'b0, 1'b0)));
    tbl.push_back(v(NOP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0, z));

    // Reset: outputs all zero, a stray ack is ignored.
    resetn = 1'b0;
    drive(ALU, 32'h999, 32'h0, 5'd7, 1'b0, 32'h0);
    repeat (2) @(posedge clock);
    #1;
    drive(NOP, 32'h0, 32'h0, 5'd0, 1'b1, 32'hFFFFFFFF);
    #4;
    check("reset", z);
    next_cycle();
    resetn = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].ctl, tbl[i].ealu, tbl[i].eb, tbl[i].ern, tbl[i].ack, tbl[i].rdata);
      #4;
      check($sformatf("vec%0d", i), tbl[i].exp);
      next_cycle();
    end

    // Reset while WAIT is pending abandons the access.
    drive(LD, 32'h80, 32'h0, 5'd1, 1'b0, 32'h0);
    #4;
    check("pre_load", z);
    next_cycle();
    drive(NOP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    #4;
    check("load_run_stall",
          o(1'b1, 1'b0, 32'h80, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h80, 5'd1, 1'b0, 1'b0));
    next_cycle();
    resetn = 1'b0;
    #4;
    check("load_wait_stall",
          o(1'b1, 1'b0, 32'h80, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h80, 5'd1, 1'b0, 1'b0));
    next_cycle();
    resetn = 1'b1;
    drive(NOP, 32'h0, 32'h0, 5'd0, 1'b1, 32'h12345678);
    #4;
    check("reset_in_wait", z);
    next_cycle();
    drive(ALU, 32'h9, 32'h0, 5'd31, 1'b1, 32'h12345678);
    #4;
    check("late_ack_ignored", z);
    next_cycle();
    drive(NOP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    #4;
    check("recover_alu",
          o(1'b0, 1'b0, 32'h9, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h9, 5'd31, 1'b0, 1'b0));
    next_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
